// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM request controller: FSM state encoding,
// default geometry and request operation codes.
package sram_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP,
    V_ISSUE,
    V_CAPTURE
  } state_t;

endpackage : sram_pkg

// File: rtl/sram_req_ctrl.sv
// Single-outstanding request controller driving a registered-read SRAM port.
// Define SRAM_READBACK_VERIFY_EN to re-read every write and flag mismatches.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  state_t state, state_nxt;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
`ifdef SRAM_READBACK_VERIFY_EN
      ISSUE:   state_nxt = (rsp_we == OP_WR) ? V_ISSUE : CAPTURE;
      V_ISSUE:   state_nxt = V_CAPTURE;
      V_CAPTURE: state_nxt = RESP;
`else
      ISSUE:   state_nxt = (rsp_we == OP_WR) ? RESP : CAPTURE;
`endif
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SRAM_READBACK_VERIFY_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // SRAM port and response registers; mem_addr/mem_din stay put after the
  // issue cycle so the SRAM's registered read sees a stable address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
`ifdef SRAM_READBACK_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            mem_wr   <= req_we;
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
            rsp_we   <= req_we;
`ifdef SRAM_READBACK_VERIFY_EN
            err_q    <= 1'b0;
`endif
          end else begin
            mem_wr <= 1'b0;
          end
        end
        ISSUE: begin
          mem_wr <= 1'b0;
`ifndef SRAM_READBACK_VERIFY_EN
          if (rsp_we == OP_WR) rsp_rdata <= '0;
`endif
        end
        CAPTURE: rsp_rdata <= mem_dout;
`ifdef SRAM_READBACK_VERIFY_EN
        V_CAPTURE: begin
          rsp_rdata <= mem_dout;
          err_q     <= (mem_dout != mem_din);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule : sram_req_ctrl

// File: tb/tb_sram_req_ctrl.sv
// Directed scoreboard bench for sram_req_ctrl with a behavioural
// registered-read SRAM (write priority, synchronous clear) on the port.
module tb_sram_req_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef SRAM_READBACK_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 2;
`endif
  localparam int RD_LAT = 3;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  logic corrupt = 1'b0;

  exp_t sb[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  // SRAM model; corrupt forces the read port to zero for error injection.
  logic [DATA_W-1:0] sram [DEPTH];
  logic [DATA_W-1:0] sram_q;
  assign mem_dout = corrupt ? '0 : sram_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= '0;
      sram_q <= '0;
    end else if (mem_wr) begin
      sram[mem_addr] <= mem_din;
    end else begin
      sram_q <= sram[mem_addr];
    end
  end

  always @(negedge clk) if (mem_wr === 1'b1) wr_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One request/response; hold = cycles rsp_ready stays low in RESP while a
  // competing request is presented; bad = corrupt the verify read-back.
  task automatic transact(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int hold, input logic bad);
    exp_t e, got;
    int lat, wr0;
    e.we = we;
    e.err = 1'b0;
    if (we) begin
      ref_mem[a] = d;
`ifdef SRAM_READBACK_VERIFY_EN
      e.rdata = bad ? '0 : d;
      e.err   = bad;
`else
      e.rdata = '0;
`endif
    end else begin
      e.rdata = ref_mem[a];
    end
    sb.push_back(e);

    @(negedge clk);
    corrupt   = bad;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    wr0 = wr_cycles;
    check("req_ready_before_accept", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check(we ? "write_latency" : "read_latency", lat, we ? WR_LAT : RD_LAT);
    if (rsp_valid !== 1'b1) begin
      void'(sb.pop_front());
      corrupt = 1'b0;
      return;
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = ~a;
      req_wdata = ~d;
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
      check("bp_req_ready", 32'(req_ready), 0);
    end

    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("sb_not_empty", 32'(sb.size()), 1);
    got = sb.pop_front();
    check("rsp_we", 32'(rsp_we), 32'(got.we));
    check("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
    check("rsp_err", 32'(rsp_err), 32'(got.err));
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    corrupt = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 0);
    check("req_ready_after_rsp", 32'(req_ready), 1);
    check("mem_wr_cycles", wr_cycles - wr0, we ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    clear_ref();

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_din", 32'(mem_din), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_we", 32'(rsp_we), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_req_ready", 32'(req_ready), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_no_mem_wr", wr_cycles, 0);

    // Basic write then read, and an unwritten address.
    transact(1'b1, 3'd5, 4'hA, 0, 1'b0);
    transact(1'b0, 3'd5, 4'h0, 0, 1'b0);
    transact(1'b0, 3'd6, 4'h0, 0, 1'b0);

    // Full sweep including the top address.
    for (int i = 0; i < DEPTH; i++) transact(1'b1, ADDR_W'(i), DATA_W'(i) ^ 4'hF, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) transact(1'b0, ADDR_W'(i), 4'h0, 0, 1'b0);

    // Backpressure on a read and a write.
    transact(1'b0, 3'd7, 4'h0, 5, 1'b0);
    transact(1'b1, 3'd1, 4'h9, 5, 1'b0);
    transact(1'b0, 3'd1, 4'h0, 0, 1'b0);

    // Reset during CAPTURE of a read of address 3.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_ref();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_req_ready", 32'(req_ready), 1);
    check("midrst_rsp_rdata", 32'(rsp_rdata), 0);
    repeat (3) begin
      @(posedge clk);
      #1 check("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    transact(1'b0, 3'd3, 4'h0, 0, 1'b0);

`ifdef SRAM_READBACK_VERIFY_EN
    // Read-back verify: clean write, then a corrupted read-back.
    transact(1'b1, 3'd2, 4'h6, 0, 1'b0);
    transact(1'b1, 3'd4, 4'h5, 0, 1'b1);
    transact(1'b0, 3'd4, 4'h0, 0, 1'b0);
`endif

    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sram_req_ctrl
